// File: rtl/mostrador_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mostrador_pkg
// Description : Shared types and segment patterns for the multiplexed
//               7-segment display stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mostrador_pkg;

  // Display sequencer states
  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    ON      = 2'd1,
    GUARD   = 2'd2
  } state_t;

  // Active-low segment patterns, bit order g..a
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  // BCD to active-low segments; codes above 9 render as a dash
  function automatic logic [6:0] digit_pattern(input logic [3:0] bcd);
    logic [6:0] pat;
    case (bcd)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_DASH;
    endcase
    return pat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_para_7seg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_para_7seg
// Description : Combinational BCD to active-low 7-segment decoder with a
//               blanking override.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_para_7seg
  import mostrador_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  // Blanking wins over the digit pattern
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      seg = digit_pattern(bcd);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mostrador_mux_7seg.sv
`default_nettype none
// ============================================================================
// Module      : mostrador_mux_7seg
// Description : Time-multiplexes four shadowed BCD digits onto a shared
//               active-low 7-segment bus with guard gaps, leading-zero
//               blanking and per-digit decimal points.
// Revision    : 1.0 - initial release
// ============================================================================
module mostrador_mux_7seg
  import mostrador_pkg::*;
#(
  parameter int ON_CYCLES    = 50000,
  parameter int GUARD_CYCLES = 1000,
  parameter int CNT_W        = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] mostrador0,
  input  logic [3:0] mostrador1,
  input  logic [3:0] mostrador2,
  input  logic [3:0] mostrador3,
  input  logic       apagar_zeros,
  input  logic [3:0] ponto,
  output logic [6:0] segmentos,
  output logic       ponto_seg,
  output logic [3:0] anodos,
  output logic       quadro
);

  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

  state_t           state, state_next;
  logic [1:0]       idx, idx_next;
  logic [CNT_W-1:0] counter, counter_next;

  logic [3:0][3:0]  shadow_dig, shadow_dig_next;
  logic [3:0]       shadow_ponto, shadow_ponto_next;
  logic             shadow_apagar, shadow_apagar_next;

  logic             capturing;
  logic [3:0]       dig_sel;
  logic             blank_sel;
  logic [3:0]       blank_vec;
  logic [6:0]       seg_dec;

  logic [6:0]       seg_nx;
  logic             dp_nx;
  logic [3:0]       an_nx;
  logic             quadro_nx;

  // A CAPTURE cycle is the one with quadro high; right after reset the
  // state is CAPTURE with quadro low, which just arms the first real frame.
  assign capturing = (state == CAPTURE) && quadro;

  // Next-state, slot index and slot counter
  always_comb begin
    state_next   = state;
    idx_next     = idx;
    counter_next = counter + 1'b1;
    case (state)
      CAPTURE: begin
        counter_next = '0;
        idx_next     = 2'd0;
        if (quadro) begin
          state_next = ON;
        end
      end
      ON: begin
        if (counter == ON_LAST) begin
          state_next   = GUARD;
          counter_next = '0;
        end
      end
      GUARD: begin
        if (counter == GUARD_LAST) begin
          counter_next = '0;
          if (idx == 2'd3) begin
            state_next = CAPTURE;
            idx_next   = 2'd0;
          end else begin
            state_next = ON;
            idx_next   = idx + 2'd1;
          end
        end
      end
      default: begin
        state_next   = CAPTURE;
        idx_next     = 2'd0;
        counter_next = '0;
      end
    endcase
  end

  // Shadow contents as they will be after this edge, so the first digit of
  // a frame can be decoded in the same edge that captures it
  always_comb begin
    shadow_dig_next    = shadow_dig;
    shadow_ponto_next  = shadow_ponto;
    shadow_apagar_next = shadow_apagar;
    if (capturing) begin
      shadow_dig_next    = {mostrador3, mostrador2, mostrador1, mostrador0};
      shadow_ponto_next  = ponto;
      shadow_apagar_next = apagar_zeros;
    end
  end

  // Leading-zero blanking; invalid codes are nonzero and stop the blanking
  always_comb begin
    blank_vec    = 4'b0000;
    blank_vec[3] = shadow_apagar_next && (shadow_dig_next[3] == 4'd0);
    blank_vec[2] = blank_vec[3] && (shadow_dig_next[2] == 4'd0);
    blank_vec[1] = blank_vec[2] && (shadow_dig_next[1] == 4'd0);
    dig_sel      = shadow_dig_next[idx_next];
    blank_sel    = blank_vec[idx_next];
  end

  bcd_para_7seg u_dec (
    .bcd   (dig_sel),
    .blank (blank_sel),
    .seg   (seg_dec)
  );

  // Output values for the state being entered
  always_comb begin
    seg_nx    = SEG_BLANK;
    dp_nx     = 1'b1;
    an_nx     = 4'b1111;
    quadro_nx = 1'b0;
    case (state_next)
      CAPTURE: quadro_nx = 1'b1;
      ON: begin
        an_nx  = ~(4'b0001 << idx_next);
        seg_nx = seg_dec;
        dp_nx  = ~shadow_ponto_next[idx_next];
      end
      default: ;
    endcase
  end

  // State, shadow and output registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= CAPTURE;
      idx           <= 2'd0;
      counter       <= '0;
      shadow_dig    <= '0;
      shadow_ponto  <= 4'b0000;
      shadow_apagar <= 1'b0;
      segmentos     <= SEG_BLANK;
      ponto_seg     <= 1'b1;
      anodos        <= 4'b1111;
      quadro        <= 1'b0;
    end else begin
      state         <= state_next;
      idx           <= idx_next;
      counter       <= counter_next;
      shadow_dig    <= shadow_dig_next;
      shadow_ponto  <= shadow_ponto_next;
      shadow_apagar <= shadow_apagar_next;
      segmentos     <= seg_nx;
      ponto_seg     <= dp_nx;
      anodos        <= an_nx;
      quadro        <= quadro_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mostrador_mux_7seg.sv
`default_nettype none
// ============================================================================
// Module      : tb_mostrador_mux_7seg
// Description : Scoreboard bench for mostrador_mux_7seg with ON_CYCLES=4,
//               GUARD_CYCLES=1 (21-cycle frames).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mostrador_mux_7seg;

  logic       clock;
  logic       reset_n;
  logic [3:0] mostrador0, mostrador1, mostrador2, mostrador3;
  logic       apagar_zeros;
  logic [3:0] ponto;
  logic [6:0] segmentos;
  logic       ponto_seg;
  logic [3:0] anodos;
  logic       quadro;

  mostrador_mux_7seg #(
    .ON_CYCLES    (4),
    .GUARD_CYCLES (1),
    .CNT_W        (4)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .mostrador0   (mostrador0),
    .mostrador1   (mostrador1),
    .mostrador2   (mostrador2),
    .mostrador3   (mostrador3),
    .apagar_zeros (apagar_zeros),
    .ponto        (ponto),
    .segmentos    (segmentos),
    .ponto_seg    (ponto_seg),
    .anodos       (anodos),
    .quadro       (quadro)
  );

  // Expected {quadro, anodos, segmentos, ponto_seg} with a tag for messages
  typedef struct {
    logic [12:0] v;
    int          test;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   test_id = 0;

  localparam logic [6:0] P0 = 7'b1000000;
  localparam logic [6:0] P1 = 7'b1111001;
  localparam logic [6:0] P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000;
  localparam logic [6:0] P4 = 7'b0011001;
  localparam logic [6:0] P5 = 7'b0010010;
  localparam logic [6:0] P6 = 7'b0000010;
  localparam logic [6:0] P7 = 7'b1111000;
  localparam logic [6:0] PB = 7'b1111111;
  localparam logic [6:0] PD = 7'b0111111;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: one output word per cycle, compared on the falling edge
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [12:0] act;
      e   = exp_q.pop_front();
      act = {quadro, anodos, segmentos, ponto_seg};
      n_total++;
      if (act === e.v) n_pass++;
      else $display("FAIL t%0d_cycle%0d got q=%b an=%b seg=%b dp=%b required q=%b an=%b seg=%b dp=%b",
                    e.test, e.cyc, act[12], act[11:8], act[7:1], act[0],
                    e.v[12], e.v[11:8], e.v[7:1], e.v[0]);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [12:0] v, input int cyc);
    exp_t e;
    e.v    = v;
    e.test = test_id;
    e.cyc  = cyc;
    exp_q.push_back(e);
  endtask

  // Queue the first n cycles of a frame: CAPTURE, then per digit 4 ON + 1 GUARD
  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [3:0] dp, input int n);
    logic [12:0] f [21];
    logic [6:0]  s [4];
    logic [3:0]  an [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    an[0] = 4'b1110; an[1] = 4'b1101; an[2] = 4'b1011; an[3] = 4'b0111;
    f[0] = {1'b1, 4'b1111, PB, 1'b1};
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 4; k++) f[1 + d*5 + k] = {1'b0, an[d], s[d], ~dp[d]};
      f[5 + d*5] = {1'b0, 4'b1111, PB, 1'b1};
    end
    for (int c = 0; c < n; c++) push(f[c], c);
  endtask

  task automatic set_digits(input logic [3:0] d3, input logic [3:0] d2,
                            input logic [3:0] d1, input logic [3:0] d0);
    mostrador3 = d3; mostrador2 = d2; mostrador1 = d1; mostrador0 = d0;
  endtask

  initial begin
    reset_n = 1'b0;
    set_digits(4'd4, 4'd3, 4'd2, 4'd1);
    apagar_zeros = 1'b0;
    ponto = 4'b0000;

    // 1: reset state, then a full frame of 4,3,2,1
    test_id = 1;
    step();
    push({1'b0, 4'b1111, PB, 1'b1}, -1);
    reset_n = 1'b1;
    push_frame(P1, P2, P3, P4, 4'b0000, 21);
    repeat (22) step();

    // 2: leading-zero blanking on 0,0,0,7 then the same without blanking
    test_id = 2;
    set_digits(4'd0, 4'd0, 4'd0, 4'd7);
    apagar_zeros = 1'b1;
    push_frame(P7, PB, PB, PB, 4'b0000, 21);
    repeat (21) step();
    apagar_zeros = 1'b0;
    push_frame(P7, P0, P0, P0, 4'b0000, 21);
    repeat (21) step();

    // 3: invalid code shows a dash and stops the blanking chain
    test_id = 3;
    set_digits(4'd1, 4'hC, 4'd0, 4'd0);
    push_frame(P0, P0, PD, P1, 4'b0000, 21);
    repeat (21) step();
    set_digits(4'd0, 4'hC, 4'd0, 4'd5);
    apagar_zeros = 1'b1;
    push_frame(P5, P0, PD, PB, 4'b0000, 21);
    repeat (21) step();

    // 4: mid-frame input change only appears after the next capture
    test_id = 4;
    set_digits(4'd0, 4'd0, 4'd0, 4'd5);
    apagar_zeros = 1'b0;
    push_frame(P5, P0, P0, P0, 4'b0000, 21);
    repeat (7) step();
    mostrador0 = 4'd6;
    repeat (14) step();
    push_frame(P6, P0, P0, P0, 4'b0000, 21);
    repeat (21) step();

    // 5: decimal point on digit 2 only while that digit is lit
    test_id = 5;
    set_digits(4'd4, 4'd3, 4'd2, 4'd1);
    ponto = 4'b0100;
    push_frame(P1, P2, P3, P4, 4'b0100, 21);
    repeat (21) step();

    // 6: reset during digit 2 ON slot, then a clean new frame
    test_id = 6;
    ponto = 4'b0000;
    push_frame(P1, P2, P3, P4, 4'b0000, 13);
    repeat (12) step();
    reset_n = 1'b0;
    step();
    push({1'b0, 4'b1111, PB, 1'b1}, -1);
    reset_n = 1'b1;
    set_digits(4'd0, 4'd0, 4'd0, 4'd2);
    push_frame(P2, P0, P0, P0, 4'b0000, 21);
    repeat (22) step();

    // Every queued expectation must have been consumed by now
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL queue_drain got %0d entries left required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
